// File: rtl/seq_num_checker_pkg.sv
// Shared constants and types for the FIX sequence-number path (generator and checker).
package seq_num_checker_pkg;
    localparam int          SEQ_WIDTH_DEF  = 32;
    localparam int          MAX_DIGITS_DEF = 10;
    localparam logic [7:0]  SOH            = 8'h01;

    typedef enum logic [2:0] {
        ST_OK       = 3'd0,
        ST_GAP      = 3'd1,
        ST_LOW      = 3'd2,
        ST_FORMAT   = 3'd3,
        ST_OVERFLOW = 3'd4
    } status_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } chk_state_e;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction
endpackage

// File: rtl/seq_num_checker_if.sv
// Byte-stream input and result output bundle of the sequence-number checker.
interface seq_num_checker_if
    import seq_num_checker_pkg::*;
#(
    parameter int SEQ_WIDTH = SEQ_WIDTH_DEF
);
    logic                 start_i;
    logic                 char_valid_i;
    logic [7:0]           char_i;
    logic                 char_ready_o;
    logic [SEQ_WIDTH-1:0] expected_seq_num_i;
    logic                 result_valid_o;
    logic [SEQ_WIDTH-1:0] seq_num_o;
    logic [2:0]           status_o;
    logic [SEQ_WIDTH-1:0] gap_o;
    logic                 busy_o;

    modport master (
        output start_i, char_valid_i, char_i, expected_seq_num_i,
        input  char_ready_o, result_valid_o, seq_num_o, status_o, gap_o, busy_o
    );

    modport slave (
        input  start_i, char_valid_i, char_i, expected_seq_num_i,
        output char_ready_o, result_valid_o, seq_num_o, status_o, gap_o, busy_o
    );
endinterface

// File: rtl/seq_num_checker_ascii_to_binary.sv
// Decimal ASCII digit accumulator with sticky overflow on value range or digit count.
module ascii_to_binary
    import seq_num_checker_pkg::*;
#(
    parameter int SEQ_WIDTH  = SEQ_WIDTH_DEF,
    parameter int MAX_DIGITS = MAX_DIGITS_DEF,
    parameter int CW         = $clog2(MAX_DIGITS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 digit_valid,
    input  logic [3:0]           digit,
    output logic [SEQ_WIDTH-1:0] value,
    output logic                 overflow,
    output logic [CW-1:0]        count
);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);

    logic [SEQ_WIDTH+3:0] ext;
    logic [SEQ_WIDTH+3:0] next_val;
    logic                 next_ovf;

    // acc*10+digit is kept 4 bits wider so range overflow is seen, not truncated away
    always_comb begin
        ext      = {4'b0, value};
        next_val = (ext << 3) + (ext << 1) + {{SEQ_WIDTH{1'b0}}, digit};
        next_ovf = (count >= MAX_CNT) || (next_val[SEQ_WIDTH+3:SEQ_WIDTH] != 4'b0);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            value    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (digit_valid && !overflow) begin
            if (next_ovf) begin
                overflow <= 1'b1;
            end else begin
                value <= next_val[SEQ_WIDTH-1:0];
                count <= count + 1'b1;
            end
        end
    end
endmodule

// File: rtl/seq_num_checker.sv
// Parses a tag-34 ASCII value and compares it with the expected inbound sequence number.
module seq_num_checker
    import seq_num_checker_pkg::*;
#(
    parameter int SEQ_WIDTH  = SEQ_WIDTH_DEF,
    parameter int MAX_DIGITS = MAX_DIGITS_DEF
) (
    input  logic               clk,
    input  logic               rst,
    seq_num_checker_if.slave   bus
);
    localparam int CW = $clog2(MAX_DIGITS + 1);

    chk_state_e           state;
    logic                 ready_q, busy_q, rvalid_q;
    logic [SEQ_WIDTH-1:0] seq_q, gap_q;
    logic [2:0]           status_q;
    logic                 fmt_err, start_pend;

    logic                 accept, is_soh, dig, go_accum, digit_valid;
    logic [SEQ_WIDTH-1:0] acc;
    logic                 ovf;
    logic [CW-1:0]        count;

    status_e              res_status;
    logic [SEQ_WIDTH-1:0] res_seq, res_gap;

    assign accept   = bus.char_valid_i && ready_q;
    assign is_soh   = (bus.char_i == SOH);
    assign dig      = is_digit(bus.char_i);
    // A start seen during REPORT is parked and takes effect from IDLE one cycle later
    assign go_accum = (bus.start_i && state != REPORT) || (state == IDLE && start_pend);
    assign digit_valid = (state == ACCUM) && accept && dig && !bus.start_i;

    ascii_to_binary #(
        .SEQ_WIDTH  (SEQ_WIDTH),
        .MAX_DIGITS (MAX_DIGITS),
        .CW         (CW)
    ) u_a2b (
        .clk         (clk),
        .rst         (rst),
        .clear       (go_accum),
        .digit_valid (digit_valid),
        .digit       (bus.char_i[3:0]),
        .value       (acc),
        .overflow    (ovf),
        .count       (count)
    );

    // Overflow outranks format: once the accumulator overflowed no later byte is decoded
    always_comb begin
        res_status = ST_OK;
        res_seq    = '0;
        res_gap    = '0;
        if (ovf) begin
            res_status = ST_OVERFLOW;
        end else if (fmt_err || count == '0) begin
            res_status = ST_FORMAT;
        end else begin
            res_seq = acc;
            if (acc > bus.expected_seq_num_i) begin
                res_status = ST_GAP;
                res_gap    = acc - bus.expected_seq_num_i;
            end else if (acc < bus.expected_seq_num_i) begin
                res_status = ST_LOW;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            rvalid_q   <= 1'b0;
            seq_q      <= '0;
            gap_q      <= '0;
            status_q   <= 3'd0;
            fmt_err    <= 1'b0;
            start_pend <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (go_accum) begin
                        state      <= ACCUM;
                        ready_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        fmt_err    <= 1'b0;
                        start_pend <= 1'b0;
                    end
                end
                ACCUM, DRAIN: begin
                    if (bus.start_i) begin
                        state   <= ACCUM;
                        fmt_err <= 1'b0;
                    end else if (accept && is_soh) begin
                        state    <= REPORT;
                        ready_q  <= 1'b0;
                        rvalid_q <= 1'b1;
                        status_q <= res_status;
                        seq_q    <= res_seq;
                        gap_q    <= res_gap;
                    end else if (state == ACCUM && accept && !dig) begin
                        state   <= DRAIN;
                        fmt_err <= 1'b1;
                    end else if (state == ACCUM && ovf) begin
                        state <= DRAIN;
                    end
                end
                REPORT: begin
                    state      <= IDLE;
                    busy_q     <= 1'b0;
                    start_pend <= bus.start_i;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.char_ready_o   = ready_q;
    assign bus.busy_o         = busy_q;
    assign bus.result_valid_o = rvalid_q;
    assign bus.seq_num_o      = seq_q;
    assign bus.gap_o          = gap_q;
    assign bus.status_o       = status_q;
endmodule
